lcd_text_engine: RTL and testbench

Parametrised character-LCD frame engine for HD44780-compatible modules, ROWS×COLS characters, 8-bit bus. Runs the power-on/init sequence, then writes a full frame from a flat character buffer on request, with correct per-row DDRAM addressing. Sits between the application's text-composition logic and the LCD pins. It generalises the fixed 4×20 text driver with row addressing, frame snapshotting, an update handshake and optional periodic refresh.

---
 rtl/lcd_pkg.sv | 55 +++++
 rtl/lcd_bus_writer.sv | 106 ++++++++++
 rtl/lcd_text_engine.sv | 210 +++++++++++++++++++++
 tb/tb_lcd_text_engine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD frame engine.
package lcd_pkg;

  // Sequencing FSM of the frame engine.
  typedef enum logic [2:0] {
    StPwrWait,
    StInit,
    StIdle,
    StAddr,
    StChar,
    StFrameEnd
  } lcd_state_e;

  // Byte-slot phases of the bus writer.
  typedef enum logic [1:0] {
    WrIdle,
    WrSetup,
    WrStrobe,
    WrGap
  } lcd_wr_state_e;

  localparam logic [7:0] FUNC_SET   = 8'h38;
  localparam logic [7:0] DISP_ON    = 8'h0C;
  localparam logic [7:0] CLEAR      = 8'h01;
  localparam logic [7:0] ENTRY_MODE = 8'h06;
  localparam logic [7:0] SET_DDRAM  = 8'h80;

  localparam logic [7:0] ROW_BASE_LO = 8'h00;
  localparam logic [7:0] ROW_BASE_HI = 8'h40;

  // Power-on command list, sent in index order.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    logic [7:0] cmd;
    unique case (idx)
      2'd0:    cmd = FUNC_SET;
      2'd1:    cmd = DISP_ON;
      2'd2:    cmd = CLEAR;
      default: cmd = ENTRY_MODE;
    endcase
    return cmd;
  endfunction

  // DDRAM start address of a row; rows 2/3 continue the lines of rows 0/1.
  function automatic logic [7:0] row_base(input logic [1:0] row, input logic [7:0] cols);
    logic [7:0] base;
    unique case (row)
      2'd0:    base = ROW_BASE_LO;
      2'd1:    base = ROW_BASE_HI;
      2'd2:    base = ROW_BASE_LO + cols;
      default: base = ROW_BASE_HI + cols;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/lcd_bus_writer.sv
// Single-byte LCD bus writer: latches a byte, strobes LCD_EN for CLK_DIV cycles,
// then waits the command or clear gap before pulsing oDone.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int unsigned CLK_DIV = 16,
  parameter int unsigned CMD_DLY = 2500,
  parameter int unsigned CLR_DLY = 100000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iStart,
  input  logic [7:0] iData,
  input  logic       iRS,
  input  logic       iGap,
  output logic       oDone,
  output logic [7:0] LCD_DATA,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_EN
);

  localparam logic [31:0] StrobeLast = 32'(CLK_DIV - 1);
  localparam logic [31:0] CmdLast    = 32'(CMD_DLY - 1);
  localparam logic [31:0] ClrLast    = 32'(CLR_DLY - 1);

  lcd_wr_state_e st_q, st_d;
  logic [31:0]   cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          rs_q, rs_d;
  logic          gap_q, gap_d;
  logic          en_q, en_d;
  logic          done_q, done_d;

  // Slot sequencing: setup cycle, EN strobe, idle gap, done pulse.
  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    rs_d   = rs_q;
    gap_d  = gap_q;
    en_d   = en_q;
    done_d = 1'b0;
    unique case (st_q)
      WrIdle: begin
        if (iStart) begin
          data_d = iData;
          rs_d   = iRS;
          gap_d  = iGap;
          st_d   = WrSetup;
        end
      end
      WrSetup: begin
        en_d  = 1'b1;
        cnt_d = StrobeLast;
        st_d  = WrStrobe;
      end
      WrStrobe: begin
        if (cnt_q == 32'd0) begin
          en_d  = 1'b0;
          cnt_d = gap_q ? ClrLast : CmdLast;
          st_d  = WrGap;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      WrGap: begin
        if (cnt_q == 32'd0) begin
          done_d = 1'b1;
          st_d   = WrIdle;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      default: st_d = WrIdle;
    endcase
  end

  // Slot state and pin registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      st_q   <= WrIdle;
      cnt_q  <= 32'd0;
      data_q <= 8'h00;
      rs_q   <= 1'b0;
      gap_q  <= 1'b0;
      en_q   <= 1'b0;
      done_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      rs_q   <= rs_d;
      gap_q  <= gap_d;
      en_q   <= en_d;
      done_q <= done_d;
    end
  end

  assign oDone    = done_q;
  assign LCD_DATA = data_q;
  assign LCD_RS   = rs_q;
  assign LCD_RW   = 1'b0;
  assign LCD_EN   = en_q;

endmodule

// File: rtl/lcd_text_engine.sv
// ROWS x COLS character-LCD frame engine: power-on init, then whole-frame writes
// from a snapshot of iDATA on request. Optional periodic refresh: LCD_AUTO_REFRESH_EN.
module lcd_text_engine
  import lcd_pkg::*;
#(
  parameter int unsigned ROWS        = 4,
  parameter int unsigned COLS        = 20,
  parameter int unsigned CLK_DIV     = 16,
  parameter int unsigned CMD_DLY     = 2500,
  parameter int unsigned CLR_DLY     = 100000,
  parameter int unsigned PWR_DLY     = 1000000,
  parameter int unsigned REFRESH_DLY = 5000000
) (
  input  logic                   iCLK,
  input  logic                   iRST_N,
  input  logic [ROWS*COLS*8-1:0] iDATA,
  input  logic                   iUPDATE,
  output logic                   oBUSY,
  output logic                   oDONE,
  output logic [7:0]             LCD_DATA,
  output logic                   LCD_RS,
  output logic                   LCD_RW,
  output logic                   LCD_EN
);

  localparam int unsigned FrameBits = ROWS * COLS * 8;
  localparam logic [31:0] PwrLast   = 32'(PWR_DLY - 1);
  localparam logic [5:0]  ColLast   = 6'(COLS - 1);
  localparam logic [1:0]  RowLast   = 2'(ROWS - 1);

  lcd_state_e           state_q, state_d;
  logic                 issued_q, issued_d;
  logic [1:0]           init_idx_q, init_idx_d;
  logic [31:0]          pwr_cnt_q, pwr_cnt_d;
  logic [1:0]           row_q, row_d;
  logic [5:0]           col_q, col_d;
  logic                 pending_q, pending_d;
  logic [FrameBits-1:0] frame_q, frame_d;
`ifdef LCD_AUTO_REFRESH_EN
  localparam logic [31:0] RefreshLast = 32'(REFRESH_DLY - 1);
  logic [31:0]          refresh_q, refresh_d;
`else
  // Periodic refresh is compiled out; REFRESH_DLY has no effect in this build.
  if (REFRESH_DLY == 0) begin : g_refresh_off
  end
`endif

  logic                 wr_start, wr_rs, wr_gap, wr_done;
  logic [7:0]           wr_data;
  logic [31:0]          char_idx;
  logic [FrameBits-1:0] frame_shift;

  // Select the snapshot byte for the current row/column.
  always_comb begin
    char_idx    = 32'(row_q) * COLS + 32'(col_q);
    frame_shift = frame_q >> (char_idx * 32'd8);
  end

  // Byte presented to the writer; one start per byte-state visit.
  always_comb begin
    wr_data  = 8'h00;
    wr_rs    = 1'b0;
    wr_gap   = 1'b0;
    wr_start = 1'b0;
    unique case (state_q)
      StInit: begin
        wr_data  = init_cmd(init_idx_q);
        wr_gap   = (init_idx_q == 2'd2);
        wr_start = !issued_q;
      end
      StAddr: begin
        wr_data  = SET_DDRAM | row_base(row_q, 8'(COLS));
        wr_start = !issued_q;
      end
      StChar: begin
        wr_data  = frame_shift[7:0];
        wr_rs    = 1'b1;
        wr_start = !issued_q;
      end
      default: ;
    endcase
  end

  // Sequencing FSM, pending-request capture and row/column stepping.
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    init_idx_d = init_idx_q;
    pwr_cnt_d  = pwr_cnt_q;
    row_d      = row_q;
    col_d      = col_q;
    pending_d  = pending_q;
    frame_d    = frame_q;
`ifdef LCD_AUTO_REFRESH_EN
    refresh_d  = refresh_q;
`endif
    // Requests arriving while busy coalesce into one pending frame.
    if (iUPDATE) pending_d = 1'b1;
    if (wr_start) issued_d = 1'b1;
    unique case (state_q)
      StPwrWait: begin
        if (pwr_cnt_q == PwrLast) begin
          state_d    = StInit;
          init_idx_d = 2'd0;
          issued_d   = 1'b0;
        end else begin
          pwr_cnt_d = pwr_cnt_q + 32'd1;
        end
      end
      StInit: begin
        if (wr_done) begin
          issued_d = 1'b0;
          if (init_idx_q == 2'd3) state_d = StIdle;
          else init_idx_d = init_idx_q + 2'd1;
        end
      end
      StIdle: begin
`ifdef LCD_AUTO_REFRESH_EN
        if (refresh_q == RefreshLast) pending_d = 1'b1;
        else refresh_d = refresh_q + 32'd1;
`endif
        if (iUPDATE || pending_q) begin
          frame_d   = iDATA;
          pending_d = 1'b0;
          row_d     = 2'd0;
          issued_d  = 1'b0;
          state_d   = StAddr;
`ifdef LCD_AUTO_REFRESH_EN
          refresh_d = 32'd0;
`endif
        end
      end
      StAddr: begin
        if (wr_done) begin
          issued_d = 1'b0;
          col_d    = 6'd0;
          state_d  = StChar;
        end
      end
      StChar: begin
        if (wr_done) begin
          issued_d = 1'b0;
          if (col_q == ColLast) begin
            if (row_q == RowLast) begin
              state_d = StFrameEnd;
            end else begin
              row_d   = row_q + 2'd1;
              state_d = StAddr;
            end
          end else begin
            col_d = col_q + 6'd1;
          end
        end
      end
      StFrameEnd: state_d = StIdle;
      default:    state_d = StPwrWait;
    endcase
  end

  // Engine state registers; reset restarts the whole power-on sequence.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= StPwrWait;
      issued_q   <= 1'b0;
      init_idx_q <= 2'd0;
      pwr_cnt_q  <= 32'd0;
      row_q      <= 2'd0;
      col_q      <= 6'd0;
      pending_q  <= 1'b0;
      frame_q    <= '0;
`ifdef LCD_AUTO_REFRESH_EN
      refresh_q  <= 32'd0;
`endif
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      init_idx_q <= init_idx_d;
      pwr_cnt_q  <= pwr_cnt_d;
      row_q      <= row_d;
      col_q      <= col_d;
      pending_q  <= pending_d;
      frame_q    <= frame_d;
`ifdef LCD_AUTO_REFRESH_EN
      refresh_q  <= refresh_d;
`endif
    end
  end

  assign oBUSY = !((state_q == StIdle) && !pending_q);
  assign oDONE = (state_q == StFrameEnd);

  lcd_bus_writer #(
    .CLK_DIV (CLK_DIV),
    .CMD_DLY (CMD_DLY),
    .CLR_DLY (CLR_DLY)
  ) u_writer (
    .iCLK     (iCLK),
    .iRST_N   (iRST_N),
    .iStart   (wr_start),
    .iData    (wr_data),
    .iRS      (wr_rs),
    .iGap     (wr_gap),
    .oDone    (wr_done),
    .LCD_DATA (LCD_DATA),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_EN   (LCD_EN)
  );

endmodule

// File: tb/tb_lcd_text_engine.sv
// Directed bench for lcd_text_engine: 2x4 panel for sequencing and timing,
// 4x20 panel for row addressing.
module tb_lcd_text_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 2x4 instance
  logic [63:0] data2 = '0;
  logic        upd2 = 1'b0;
  logic        busy2, done2, rs2, rw2, en2;
  logic [7:0]  lcd2;

  lcd_text_engine #(
    .ROWS (2), .COLS (4), .CLK_DIV (2), .CMD_DLY (3), .CLR_DLY (6), .PWR_DLY (10),
    .REFRESH_DLY (50)
  ) u_dut (
    .iCLK (clk), .iRST_N (rst_n), .iDATA (data2), .iUPDATE (upd2), .oBUSY (busy2),
    .oDONE (done2), .LCD_DATA (lcd2), .LCD_RS (rs2), .LCD_RW (rw2), .LCD_EN (en2)
  );

  // 4x20 instance
  logic [639:0] data4 = '0;
  logic         upd4 = 1'b0;
  logic         busy4, done4, rs4, rw4, en4;
  logic [7:0]   lcd4;

  lcd_text_engine #(
    .ROWS (4), .COLS (20), .CLK_DIV (2), .CMD_DLY (3), .CLR_DLY (6), .PWR_DLY (10),
    .REFRESH_DLY (50)
  ) u_dut4 (
    .iCLK (clk), .iRST_N (rst_n), .iDATA (data4), .iUPDATE (upd4), .oBUSY (busy4),
    .oDONE (done4), .LCD_DATA (lcd4), .LCD_RS (rs4), .LCD_RW (rw4), .LCD_EN (en4)
  );

  // Bus monitors: record {RS, DATA} and cycle of every EN rising edge.
  logic [8:0] bytes_q[$];
  int         rise_q[$];
  logic [7:0] cmd4_q[$];
  logic       en2_prev = 1'b0, en4_prev = 1'b0;
  int         done_cnt = 0, done4_cnt = 0;

  always @(negedge clk) begin
    if (en2 && !en2_prev) begin
      bytes_q.push_back({rs2, lcd2});
      rise_q.push_back(cyc);
    end
    if (en4 && !en4_prev && !rs4) cmd4_q.push_back(lcd4);
    if (done2) done_cnt <= done_cnt + 1;
    if (done4) done4_cnt <= done4_cnt + 1;
    en2_prev <= en2;
    en4_prev <= en4;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_update();
    @(negedge clk);
    upd2 = 1'b1;
    @(negedge clk);
    upd2 = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy2 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, busy2, 1'b0);
  endtask

  task automatic wait_bytes(input int n, input int budget, input string tag);
    int k = 0;
    while (bytes_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, bytes_q.size() >= n, 1'b1);
  endtask

  task automatic wait_done(input int target, input int budget, input string tag);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, done_cnt >= target, 1'b1);
  endtask

  logic [8:0] exp_init[4];
  logic [8:0] exp_abcd[10];
  logic [8:0] exp_z[10];
  logic [7:0] exp_addr4[4];

  initial begin
    int d0;
    int k;
    exp_init  = '{9'h038, 9'h00C, 9'h001, 9'h006};
    exp_abcd  = '{9'h080, 9'h141, 9'h142, 9'h143, 9'h144,
                  9'h0C0, 9'h145, 9'h146, 9'h147, 9'h148};
    exp_z     = '{9'h080, 9'h15A, 9'h15A, 9'h15A, 9'h15A,
                  9'h0C0, 9'h15A, 9'h15A, 9'h15A, 9'h15A};
    exp_addr4 = '{8'h80, 8'hC0, 8'h94, 8'hD4};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_data", lcd2, 8'h00);
    check("rst_rs", rs2, 1'b0);
    check("rst_rw", rw2, 1'b0);
    check("rst_en", en2, 1'b0);
    check("rst_busy", busy2, 1'b1);
    check("rst_done", done2, 1'b0);

    // Power-on wait and init sequence
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("pwr_no_en", bytes_q.size(), 0);
    wait_idle(300, "init_busy_low");
    check("init_count", bytes_q.size(), 4);
    for (int i = 0; i < 4 && i < bytes_q.size(); i++) check("init_byte", bytes_q[i], exp_init[i]);
    if (rise_q.size() >= 4) begin
      check("init_slot_cmd", rise_q[1] - rise_q[0], 8);
      check("init_slot_clr", rise_q[3] - rise_q[2], 11);
    end
    check("init_no_done", done_cnt, 0);
    check("init_rw", rw2, 1'b0);

    // One frame "ABCDEFGH"
    data2 = "HGFEDCBA";
    bytes_q.delete();
    rise_q.delete();
    pulse_update();
    check("frame_busy", busy2, 1'b1);
    wait_done(1, 300, "frame_done");
    wait_idle(50, "frame_idle");
    check("frame_count", bytes_q.size(), 10);
    for (int i = 0; i < 10 && i < bytes_q.size(); i++) check("frame_byte", bytes_q[i], exp_abcd[i]);
    check("frame_one_done", done_cnt, 1);

    // Data change mid-frame plus three coalescing requests
    d0 = done_cnt;
    bytes_q.delete();
    pulse_update();
    wait_bytes(3, 200, "mid_progress");
    data2 = "ZZZZZZZZ";
    pulse_update();
    pulse_update();
    pulse_update();
    wait_done(d0 + 2, 600, "mid_two_frames");
    wait_idle(50, "mid_idle");
    repeat (100) @(negedge clk);
    for (int i = 0; i < 10 && i < bytes_q.size(); i++) check("snap_byte", bytes_q[i], exp_abcd[i]);
    for (int i = 10; i < 20 && i < bytes_q.size(); i++) check("z_byte", bytes_q[i], exp_z[i-10]);
`ifdef LCD_AUTO_REFRESH_EN
    check("refresh_more_frames", done_cnt > d0 + 2, 1'b1);
`else
    check("coalesce_frames", done_cnt - d0, 2);
    check("coalesce_bytes", bytes_q.size(), 20);
`endif

    // Reset during the third character
    bytes_q.delete();
    wait_idle(300, "pre_rst_idle");
    bytes_q.delete();
    pulse_update();
    wait_bytes(4, 200, "rst_reach_char3");
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_data", lcd2, 8'h00);
    check("arst_rs", rs2, 1'b0);
    check("arst_en", en2, 1'b0);
    check("arst_busy", busy2, 1'b1);
    check("arst_done", done2, 1'b0);
    @(negedge clk);
    bytes_q.delete();
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rerun_pwr_no_en", bytes_q.size(), 0);
    wait_bytes(1, 100, "rerun_first");
    if (bytes_q.size() >= 1) check("rerun_func_set", bytes_q[0], 9'h038);
    wait_idle(300, "rerun_idle");

    // 4x20 row addressing
    k = 0;
    while (busy4 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("wide_init_idle", busy4, 1'b0);
    d0 = done4_cnt;
    cmd4_q.delete();
    @(negedge clk);
    upd4 = 1'b1;
    @(negedge clk);
    upd4 = 1'b0;
    k = 0;
    while (done4_cnt == d0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("wide_done", done4_cnt - d0, 1);
    check("wide_addr_count", cmd4_q.size(), 4);
    for (int i = 0; i < 4 && i < cmd4_q.size(); i++) check("wide_addr", cmd4_q[i], exp_addr4[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
